alu_mdu: RTL and testbench
==========================

# alu_mdu

Iterative multiply/divide unit: the sequential companion to the single-cycle CPU ALU, generalised to a parametrised data width. It accepts one signed or unsigned multiply or divide per start pulse, computes it over WIDTH cycles, and holds the result in architectural HI/LO registers. HI/LO can also be loaded directly (MTHI/MTLO). It sits beside the ALU in the execute stage; the pipeline stalls on `busy`.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when `busy`=0.
- op  in  2  00 = mult (signed), 01 = multu, 10 = div (signed), 11 = divu; sampled with `start`.
- din1  in  WIDTH  multiplicand / dividend; sampled with `start`.
- din2  in  WIDTH  multiplier / divisor; sampled with `start`.
- hi_we  in  1  direct write to HI from `wdata`.
- lo_we  in  1  direct write to LO from `wdata`.
- wdata  in  WIDTH  direct-write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO receive a result.
- div0  out  1  sticky flag: the last completed divide had a zero divisor; cleared by the next accepted `start`.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start`=1:
  - latch `op`, |din1|, |din2| (magnitudes for signed ops), result sign and dividend sign;
  - counter = WIDTH-1; `div0` cleared; next state CALC.
- CALC, multiply: one shift-add step per cycle on a 2·WIDTH-bit accumulator.
- CALC, divide: one restoring shift-subtract step per cycle, producing a WIDTH-bit quotient and remainder.
- CALC: counter decrements each cycle; at counter = 0 the next state is FIX.
- FIX:
  - apply sign correction;
  - write HI/LO; `done`=1 for the following cycle; next state IDLE.
- Signed multiply: the product is negated iff the operand signs differ; the full 2·WIDTH-bit product is split HI:LO.
- Signed divide:
  - quotient is negated iff the signs differ; truncation is toward zero;
  - remainder takes the dividend's sign.
- Signed overflow, MIN / -1: LO = MIN, HI = 0. No flag is raised.
- Divide by zero, signed or unsigned:
  - LO = all ones, HI = din1 as sampled (unmodified);
  - `div0` = 1 at the same edge as `done`.
- Direct writes: `hi_we`/`lo_we` take effect only when `busy`=0.
  - Writes are ignored while `busy`=1.
  - A write in the same cycle as an accepted `start` still lands; the later result overwrites it.
- `start` while `busy`=1 is ignored and not queued.
- Arithmetic is modulo 2^WIDTH per register; HI/LO never hold X.

## Timing
- Reset, asynchronous: state = IDLE; busy = 0, done = 0, div0 = 0, hi = 0, lo = 0. Reset mid-operation aborts the operation with no HI/LO update.
- Edge E0 samples `start`:
  - `busy`=1 from after E0 through after E(WIDTH+1);
  - HI/LO update and `done`=1 after E(WIDTH+1);
  - `busy`=0 in that same cycle.
- Latency from start edge to result: WIDTH+1 edges (33 for WIDTH=32). Throughput: one operation per WIDTH+2 cycles.
- A back-to-back `start` is accepted in the `done` cycle.
- HI/LO hold their value between writes; the outputs are registered, with no combinational path from inputs.

## Test plan
- Multiply, unsigned overflow: reset; multu 0xFFFFFFFF × 0xFFFFFFFF -> after 33 edges, `done` pulses; hi = 0xFFFFFFFE, lo = 0x00000001; `busy` high for exactly 33 cycles.
- Multiply, signed: mult -3 × 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. Then multu 0x80000000 × 2 -> hi = 0x00000001, lo = 0.
- Divide, signed: div -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- Divide, overflow and unsigned: div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0; divu 100 / 7 -> lo = 14, hi = 2.
- Divide by zero: divu 0x1234 / 0 -> lo = 0xFFFFFFFF, hi = 0x1234, div0 = 1; the next start clears div0.
- Hazards and reset:
  - start a second op mid-CALC -> ignored, first result intact;
  - hi_we while busy -> no effect; lo_we when idle -> lo = wdata next cycle;
  - rst_n low mid-CALC -> busy/done/hi/lo = 0 immediately;
  - repeat the first scenario with WIDTH = 8 -> done after 9 edges.

Source files
------------

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/result bundle for the iterative multiply/divide unit.
//
// Handshake: `start` is a request that is accepted on a rising edge exactly
// when `busy`=0; op/din1/din2 are captured on that edge. A request while
// busy=1 is dropped, not queued. `done` pulses for one cycle when HI/LO
// take a new result. hi_we/lo_we are direct register writes, honoured
// only while busy=0.
//
// Signals:
//   start, op[1:0], din1, din2   request (master -> unit)
//   hi_we, lo_we, wdata          direct HI/LO writes (master -> unit)
//   busy, done, div0, hi, lo     status and results (unit -> master)
//   state_dbg[1:0]               FSM state for observation (0 IDLE, 1 CALC, 2 FIX)
interface alu_mdu_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       state_dbg;

    modport master (
        output start, op, din1, din2, hi_we, lo_we, wdata,
        input  busy, done, div0, hi, lo, state_dbg
    );

    modport slave (
        input  start, op, din1, din2, hi_we, lo_we, wdata,
        output busy, done, div0, hi, lo, state_dbg
    );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: iterative signed/unsigned multiply and divide with HI/LO registers.
//
// One operation per accepted start: operands are reduced to magnitudes,
// WIDTH shift-add (multiply) or restoring shift-subtract (divide) steps run
// in CALC, and FIX applies the sign correction and writes HI/LO.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any operation)
//   bus    alu_mdu_if.slave: start/op/din1/din2 request, hi_we/lo_we/wdata
//          direct writes, busy/done/div0/hi/lo results, state_dbg
//
// op: 00 mult, 01 multu, 10 div, 11 divu (bit 1 = divide, bit 0 = unsigned).
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    alu_mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               res_neg;
    logic               dvd_neg;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, div0_q;

    logic               accept, busy_c, res_we;

    // Operand magnitudes for the signed forms
    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.din1[WIDTH-1];
    assign b_neg     = signed_op & bus.din2[WIDTH-1];
    assign a_mag     = a_neg ? -bus.din1 : bus.din1;
    assign b_mag     = b_neg ? -bus.din2 : bus.din2;

    // Multiply step: acc = {partial product, remaining multiplier bits};
    // add the multiplicand on a 1 bit, then shift the whole pair right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide step: acc = {remainder, remaining dividend / quotient bits}.
    // The shifted remainder needs one extra bit before the compare.
    logic [WIDTH:0]     rem_sh, div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, b_q};
    assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Sign-corrected results, valid in FIX
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_div0;

    assign prod = res_neg ? -acc : acc;
    assign quot = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = dvd_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        res_hi   = prod[2*WIDTH-1:WIDTH];
        res_lo   = prod[WIDTH-1:0];
        res_div0 = 1'b0;
        if (is_div) begin
            res_div0 = (b_q == '0);
            // With a zero divisor every step subtracts nothing, so the
            // remainder ends as |din1| and re-signing it restores din1.
            // Quotient bits are all ones; force LO regardless of sign.
            res_hi   = rem;
            res_lo   = res_div0 ? '1 : quot;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // FSM: next state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = CALC;
            CALC:    if (cnt == '0) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_c = (state != IDLE);
        accept = (state == IDLE) && bus.start;
        res_we = (state == FIX);
    end

    // Operand capture and iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            dvd_neg <= 1'b0;
            b_q     <= '0;
            acc     <= '0;
        end else if (accept) begin
            cnt     <= CW'(WIDTH - 1);
            is_div  <= bus.op[1];
            res_neg <= a_neg ^ b_neg;
            dvd_neg <= a_neg;
            b_q     <= b_mag;
            acc     <= {{WIDTH{1'b0}}, a_mag};
        end else if (state == CALC) begin
            cnt <= cnt - 1'b1;
            acc <= is_div ? div_next : mul_next;
        end
    end

    // Architectural HI/LO; a result in FIX wins, direct writes only when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            div0_q <= 1'b0;
        end else begin
            done_q <= res_we;
            if (res_we) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (!busy_c) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
            if (accept)      div0_q <= 1'b0;
            else if (res_we) div0_q <= res_div0;
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_q;
    assign bus.div0      = div0_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: self-checking bench for alu_mdu (WIDTH=32 main instance,
// WIDTH=8 second instance for the narrow-width latency case).
module tb_alu_mdu;
    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [64:0] exp_q[$];

    alu_mdu_if #(.WIDTH(32)) bus  ();
    alu_mdu_if #(.WIDTH(8))  bus8 ();

    alu_mdu #(.WIDTH(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_mdu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Returns {div0, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint la, lb;
        int     sa, sb, q, r;
        logic [63:0] p;
        logic [64:0] res;
        res = '0;
        case (o)
            2'b00: begin
                la = $signed(a); lb = $signed(b);
                p = la * lb;
                res = {1'b0, p};
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                res = {1'b0, p};
            end
            2'b10: begin
                if (b == 32'd0)
                    res = {1'b1, a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {1'b0, 32'd0, 32'h8000_0000};
                else begin
                    sa = $signed(a); sb = $signed(b);
                    q = sa / sb; r = sa % sb;
                    res = {1'b0, 32'(r), 32'(q)};
                end
            end
            default: begin
                if (b == 32'd0) res = {1'b1, a, 32'hFFFF_FFFF};
                else            res = {1'b0, a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a negedge; returns just after E0.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.din1  = a;
        bus.din2  = b;
        @(posedge clk);
    endtask

    // Waits for done, counting edges after E0 and busy cycles. Returns at the
    // negedge of the done cycle.
    task automatic wait_done(output int edges, output int bcyc, output bit ok);
        edges = 0; bcyc = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
            end
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) bcyc++;
            @(posedge clk);
            edges++;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: no done within 200 cycles");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.div0, bus.state_dbg} !== 5'b0 ||
            bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b div0=%b st=%0d hi=%h lo=%h required all 0",
                     bus.busy, bus.done, bus.div0, bus.state_dbg, bus.hi, bus.lo);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul;
        logic [1:0]  ops[3] = '{2'b01, 2'b00, 2'b01};
        logic [31:0] as[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000};
        logic [31:0] bs[3]  = '{32'hFFFF_FFFF, 32'd5, 32'd2};
        logic [31:0] ehs[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};
        logic [31:0] els[3] = '{32'h0000_0001, 32'hFFFF_FFF1, 32'h0000_0000};
        int edges, bcyc;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            launch(ops[i], as[i], bs[i]);
            wait_done(edges, bcyc, ok);
            if (ok) begin
                n_cmp++;
                if (bus.hi !== ehs[i] || bus.lo !== els[i]) begin
                    n_err++;
                    $display("FAIL mul_%0d: hi=%h lo=%h required hi=%h lo=%h",
                             i, bus.hi, bus.lo, ehs[i], els[i]);
                end
                if (i == 0) begin
                    n_cmp++;
                    if (edges != 33 || bcyc != 33) begin
                        n_err++;
                        $display("FAIL mul_latency: edges=%0d busy_cycles=%0d required 33/33",
                                 edges, bcyc);
                    end
                    n_cmp++;
                    if (bus.busy !== 1'b0) begin
                        n_err++;
                        $display("FAIL busy_in_done_cycle: busy=%b required 0", bus.busy);
                    end
                end
            end
        end
    endtask

    task automatic test_div;
        logic [1:0]  ops[3] = '{2'b10, 2'b10, 2'b11};
        logic [31:0] as[3]  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
        logic [31:0] bs[3]  = '{32'd2, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] ehs[3] = '{32'hFFFF_FFFF, 32'd0, 32'd2};
        logic [31:0] els[3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd14};
        int edges, bcyc;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            launch(ops[i], as[i], bs[i]);
            wait_done(edges, bcyc, ok);
            if (ok) begin
                n_cmp++;
                if (bus.hi !== ehs[i] || bus.lo !== els[i] || bus.div0 !== 1'b0) begin
                    n_err++;
                    $display("FAIL div_%0d: hi=%h lo=%h div0=%b required hi=%h lo=%h div0=0",
                             i, bus.hi, bus.lo, bus.div0, ehs[i], els[i]);
                end
            end
        end
    endtask

    task automatic test_div0;
        logic [1:0]  ops[3] = '{2'b11, 2'b10, 2'b10};
        logic [31:0] as[3]  = '{32'h0000_1234, 32'hFFFF_FF00, 32'h8000_0000};
        int edges, bcyc;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            launch(ops[i], as[i], 32'd0);
            wait_done(edges, bcyc, ok);
            if (ok) begin
                n_cmp++;
                if (bus.hi !== as[i] || bus.lo !== 32'hFFFF_FFFF || bus.div0 !== 1'b1) begin
                    n_err++;
                    $display("FAIL div0_%0d: hi=%h lo=%h div0=%b required hi=%h lo=ffffffff div0=1",
                             i, bus.hi, bus.lo, bus.div0, as[i]);
                end
            end
        end
        // Next accepted start clears the sticky flag
        @(negedge clk);
        launch(2'b01, 32'd3, 32'd3);
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.div0 !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL div0_clear: div0=%b busy=%b required div0=0 busy=1", bus.div0, bus.busy);
        end
        wait_done(edges, bcyc, ok);
    endtask

    task automatic pick_operand(output logic [31:0] v);
        case ($urandom_range(0, 6))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 15));
            4:       v = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [64:0] exp_v;
        int edges, bcyc;
        bit ok;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            pick_operand(a);
            pick_operand(b);
            exp_q.push_back(model(o, a, b));
            @(negedge clk);
            launch(o, a, b);
            wait_done(edges, bcyc, ok);
            exp_v = exp_q.pop_front();
            if (ok) begin
                n_cmp++;
                if ({bus.div0, bus.hi, bus.lo} !== exp_v) begin
                    n_err++;
                    $display("FAIL random_%0d op=%0d a=%h b=%h: div0=%b hi=%h lo=%h required div0=%b hi=%h lo=%h",
                             i, o, a, b, bus.div0, bus.hi, bus.lo, exp_v[64], exp_v[63:32], exp_v[31:0]);
                end
            end
        end
    endtask

    task automatic test_start_ignored;
        int edges, bcyc;
        bit ok, seen_busy;
        @(negedge clk);
        launch(2'b01, 32'd1000, 32'd1000);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.din1 = 32'd1; bus.din2 = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(edges, bcyc, ok);
        if (ok) begin
            n_cmp++;
            if (bus.hi !== 32'd0 || bus.lo !== 32'd1_000_000) begin
                n_err++;
                $display("FAIL start_ignored_result: hi=%h lo=%h required hi=0 lo=%h",
                         bus.hi, bus.lo, 32'd1_000_000);
            end
        end
        seen_busy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) seen_busy = 1'b1;
        end
        n_cmp++;
        if (seen_busy) begin
            n_err++;
            $display("FAIL start_not_queued: busy=1 seen after done required 0");
        end
    endtask

    task automatic test_direct_writes;
        int edges, bcyc;
        bit ok;
        @(negedge clk);
        bus.hi_we = 1'b1; bus.wdata = 32'h1111_2222;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.lo_we = 1'b0;
        n_cmp++;
        if (bus.hi !== 32'h1111_2222 || bus.lo !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL idle_writes: hi=%h lo=%h required hi=11112222 lo=cafef00d", bus.hi, bus.lo);
        end
        // Write while busy is dropped
        launch(2'b01, 32'd3, 32'd4);
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        n_cmp++;
        if (bus.hi !== 32'h1111_2222) begin
            n_err++;
            $display("FAIL busy_write_ignored: hi=%h required 11112222", bus.hi);
        end
        wait_done(edges, bcyc, ok);
        if (ok) begin
            n_cmp++;
            if (bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
                n_err++;
                $display("FAIL busy_write_result: hi=%h lo=%h required 0/c", bus.hi, bus.lo);
            end
        end
        // Write together with an accepted start lands, then the result wins
        @(negedge clk);
        bus.lo_we = 1'b1; bus.wdata = 32'h0000_5A5A;
        launch(2'b01, 32'd6, 32'd7);
        @(negedge clk);
        bus.start = 1'b0; bus.lo_we = 1'b0;
        n_cmp++;
        if (bus.lo !== 32'h0000_5A5A) begin
            n_err++;
            $display("FAIL write_with_start: lo=%h required 00005a5a", bus.lo);
        end
        wait_done(edges, bcyc, ok);
        if (ok) begin
            n_cmp++;
            if (bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
                n_err++;
                $display("FAIL write_with_start_result: hi=%h lo=%h required 0/2a", bus.hi, bus.lo);
            end
        end
    endtask

    task automatic test_back_to_back;
        int edges, bcyc;
        bit ok;
        @(negedge clk);
        launch(2'b01, 32'd7, 32'd9);
        wait_done(edges, bcyc, ok);
        // Issue the next request in the done cycle itself
        launch(2'b11, 32'd100, 32'd7);
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.lo !== 32'd63) begin
            n_err++;
            $display("FAIL back_to_back_accept: busy=%b lo=%h required busy=1 lo=3f", bus.busy, bus.lo);
        end
        wait_done(edges, bcyc, ok);
        if (ok) begin
            n_cmp++;
            if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
                n_err++;
                $display("FAIL back_to_back_result: hi=%h lo=%h required 2/e", bus.hi, bus.lo);
            end
        end
    endtask

    task automatic test_reset_mid;
        int edges, bcyc;
        bit ok;
        @(negedge clk);
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 ||
            bus.state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h st=%0d required all 0",
                     bus.busy, bus.done, bus.hi, bus.lo, bus.state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h required all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        launch(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        wait_done(edges, bcyc, ok);
        if (ok) begin
            n_cmp++;
            if (bus.hi !== 32'd0 || bus.lo !== 32'd6) begin
                n_err++;
                $display("FAIL after_reset_op: hi=%h lo=%h required 0/6", bus.hi, bus.lo);
            end
        end
    endtask

    task automatic test_width8;
        logic [1:0] ops[2] = '{2'b01, 2'b10};
        logic [7:0] as[2]  = '{8'hFF, 8'hF9};
        logic [7:0] bs[2]  = '{8'hFF, 8'h02};
        logic [7:0] ehs[2] = '{8'hFE, 8'hFF};
        logic [7:0] els[2] = '{8'h01, 8'hFD};
        int  edges, bcyc;
        bit  ok;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus8.start = 1'b1; bus8.op = ops[i]; bus8.din1 = as[i]; bus8.din2 = bs[i];
            @(posedge clk);
            edges = 0; bcyc = 0; ok = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                bus8.start = 1'b0;
                if (bus8.done === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                if (bus8.busy === 1'b1) bcyc++;
                @(posedge clk);
                edges++;
            end
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL w8_timeout_%0d: no done within 100 cycles", i);
            end else if (bus8.hi !== ehs[i] || bus8.lo !== els[i] || edges != 9 || bcyc != 9) begin
                n_err++;
                $display("FAIL w8_%0d: hi=%h lo=%h edges=%0d busy=%0d required hi=%h lo=%h 9/9",
                         i, bus8.hi, bus8.lo, edges, bcyc, ehs[i], els[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.din1 = '0; bus.din2 = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        bus8.start = 1'b0; bus8.op = 2'b00; bus8.din1 = '0; bus8.din2 = '0;
        bus8.hi_we = 1'b0; bus8.lo_we = 1'b0; bus8.wdata = '0;

        test_reset();
        test_mul();
        test_div();
        test_div0();
        test_random();
        test_start_ignored();
        test_direct_writes();
        test_back_to_back();
        test_reset_mid();
        test_width8();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
